// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier dot-product datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul_pkg;

    // Width of one product coming out of the 4x4 array multiplier.
    localparam int PROD_W    = 8;
    // Width of one serialized output nibble.
    localparam int NIB_W     = 4;
    // Default accumulator and term-counter widths.
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    // ACCUM: taking terms on the input side.
    // DRAIN: shifting the finished sum out, input side stalled.
    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/mul_dot_accumulator_nibble_serializer.sv
// Parallel-load shift register that emits a word as NIB_W-bit nibbles, LSB first.
// Latency: nibble 0 visible the cycle after load; one nibble per shift.
// Backpressure: shift is only asserted by the owner on a downstream handshake.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        start pulse, captures load_dat and rewinds the nibble index
//   load_dat    parallel word to serialize
//   active      owner is draining; gates the first/last markers
//   shift       advance to the next nibble (downstream accepted current one)
//   out_nibble  current low nibble of the shift register
//   out_first   current nibble is nibble 0
//   out_last    current nibble is the most significant one
module nibble_serializer
    import mul_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_dat,
    input  logic             active,
    input  logic             shift,
    output logic [NIB_W-1:0] out_nibble,
    output logic             out_first,
    output logic             out_last
);

    localparam int NIBS  = W / NIB_W;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    logic [W-1:0]     sh_q,      sh_d;
    logic [IDX_W-1:0] nib_idx_q, nib_idx_d;

    always_comb begin
        sh_d      = sh_q;
        nib_idx_d = nib_idx_q;
        if (load) begin
            sh_d      = load_dat;
            nib_idx_d = '0;
        end else if (shift) begin
            // Zero-fill from the top so the register is clean once drained.
            sh_d      = sh_q >> NIB_W;
            nib_idx_d = nib_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            nib_idx_q <= '0;
        end else begin
            sh_q      <= sh_d;
            nib_idx_q <= nib_idx_d;
        end
    end

    assign out_nibble = sh_q[NIB_W-1:0];
    // Markers are qualified by active so they read 0 outside a drain.
    assign out_first  = active && (nib_idx_q == '0);
    assign out_last   = active && (nib_idx_q == IDX_W'(NIBS - 1));

endmodule

// File: rtl/mul_dot_accumulator.sv
// Accumulates multiplier products into a dot-product sum and drains it as nibbles.
// Latency: nibble 0 valid right after the in_last beat edge; NIBS cycles to drain.
// Backpressure: in_ready low for the whole drain; out_ready low freezes all outputs.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     in_product valid; a beat is in_valid & in_ready
//   in_product   unsigned 8-bit product from the multiplier
//   in_last      final term of the vector (qualified by in_valid)
//   in_ready     block accepts a term this cycle
//   out_valid    out_nibble valid (high for the whole drain)
//   out_nibble   current nibble of the finished sum, LSB first
//   out_first    current nibble is nibble 0
//   out_last     current nibble is nibble NIBS-1
//   out_ready    consumer accepts the current nibble
//   overflow     sum wrapped during this vector (sticky until drain completes)
//   term_count   terms in the vector being drained, saturating
module mul_dot_accumulator
    import mul_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PROD_W-1:0] in_product,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [NIB_W-1:0] out_nibble,
    output logic             out_first,
    output logic             out_last,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] term_count
);

    localparam int NIBS = ACC_W / NIB_W;

    generate
        if ((ACC_W % NIB_W) != 0 || ACC_W < 8) begin : g_bad_acc_w
            $error("mul_dot_accumulator: ACC_W must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_e           state_q,      state_d;
    logic [ACC_W-1:0] acc_q,        acc_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             ovf_q,        ovf_d;
    logic [CNT_W-1:0] term_count_q, term_count_d;
    logic             in_ready_q,   in_ready_d;

    logic             beat;
    logic             ser_load;
    logic             draining;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    // One extra bit on the adder gives the carry-out used for the wrap flag.
    assign sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign draining = (state_q == DRAIN);
    // in_ready_q is only ever high in ACCUM, so it fully qualifies a beat.
    assign beat     = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        term_count_d = term_count_q;
        ser_load     = 1'b0;
        case (state_q)
            ACCUM: begin
                if (beat) begin
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    if (in_last) begin
                        // Hand the final sum (including this term) to the
                        // serializer and start the next vector from zero.
                        ser_load     = 1'b1;
                        term_count_d = cnt_inc;
                        acc_d        = '0;
                        cnt_d        = '0;
                        state_d      = DRAIN;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                        cnt_d = cnt_inc;
                    end
                end
            end
            DRAIN: begin
                if (out_ready && out_last) begin
                    state_d = ACCUM;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Registered ready: low during reset, high from the first edge after
    // release, and rising only after the final nibble handshake edge.
    assign in_ready_d = (state_d == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            term_count_q <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            term_count_q <= term_count_d;
            in_ready_q   <= in_ready_d;
        end
    end

    nibble_serializer #(
        .W (ACC_W)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_dat   (sum_ext[ACC_W-1:0]),
        .active     (draining),
        .shift      (draining && out_ready),
        .out_nibble (out_nibble),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = draining;
    assign overflow   = ovf_q;
    assign term_count = term_count_q;

endmodule

// File: doc/mul_dot_accumulator.md
Name: mul_dot_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier's 8-bit product, sitting between the multiplier and the uo_out pins.
- Accumulates a vector of products into a dot-product sum, one matrix-row x column term per beat.
- At end of vector, serializes the sum out as 4-bit nibbles, least significant first, over a valid/ready handshake.
- The serialized output is narrow enough for the pin-limited top level.

Parameters:
- ACC_W, 16, accumulator width in bits. Must be a multiple of 4 and at least 8.
- CNT_W, 8, term counter width in bits.
- NIBS is derived as ACC_W/4. It is a localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_product is valid this cycle.
- in_product  input  8  product from the multiplier, unsigned.
- in_last  input  1  marks the final term of the vector; qualified by in_valid.
- in_ready  output  1  block accepts a term this cycle.
- out_valid  output  1  out_nibble is valid.
- out_nibble  output  4  current nibble of the sum.
- out_first  output  1  current nibble is nibble 0 (LSB).
- out_last  output  1  current nibble is nibble NIBS-1.
- out_ready  input  1  consumer accepts the nibble.
- overflow  output  1  the accumulated sum wrapped during this vector.
- term_count  output  CNT_W  number of terms in the vector being drained.

Behaviour:
- Reset, asynchronous, while rst_n is low:
  - state goes to ACCUM; acc, sh, nib_idx, cnt, ovf and all outputs go to 0.
  - in_ready reads 1 after the reset release edge.
  - Reset asserted mid-vector or mid-drain discards all partial data; no nibble is emitted afterwards.
- All outputs are driven from registers or directly from state; there are no combinational paths from in_* to out_*.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is in_valid & in_ready.
  - On a beat without in_last:
    - acc <= acc + zero-extended in_product, modulo 2^ACC_W.
    - ovf is set (sticky) on carry-out.
    - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - On a beat with in_last:
    - sh <= acc + in_product; ovf updates the same way; term_count <= cnt+1 (saturating).
    - acc <= 0, cnt <= 0, nib_idx <= 0; go to DRAIN.
  - A single-term vector (in_last on the first beat) is legal; its sum equals that product.
- State DRAIN:
  - in_ready=0; in_valid and in_product are ignored.
  - out_valid=1 and out_nibble=sh[3:0].
  - out_first = (nib_idx==0) and out_last = (nib_idx==NIBS-1).
  - overflow and term_count hold for the whole drain.
  - On out_ready: sh <= sh>>4 and nib_idx <= nib_idx+1.
  - On out_ready when out_last: go to ACCUM and clear ovf.
  - out_ready low holds every output stable for any number of cycles.
- Timing:
  - Latency: a last beat at edge N gives out_valid=1 with nibble 0 immediately after edge N.
  - A full drain with out_ready tied high takes NIBS cycles.
  - There is one guaranteed ACCUM cycle boundary: in_ready rises only after the final nibble handshake edge. There is no overlap of input and drain.
- Width rules: all arithmetic is unsigned. The sum is exact modulo 2^ACC_W, and overflow flags any wrap.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum {ACCUM, DRAIN};
  - PROD_W=8 and NIB_W=4;
  - the default ACC_W and CNT_W.
- One natural sub-module: nibble_serializer (sh, nib_idx, out_* handshake), loaded with a parallel word plus a start pulse.
- The accumulator and counter stay in the top module.

Test Plan:
- Basic vector (ACC_W=16), out_ready=1:
  - Stimulus: beats 0x0C, then 0x23 with in_last.
  - Response: nibbles F,2,0,0 on 4 consecutive cycles; out_first on F, out_last on the final 0; term_count=2; overflow=0.
- Single term:
  - Stimulus: 0xE1 (15x15) with in_last.
  - Response: nibbles 1,E,0,0; term_count=1; in_ready=0 for exactly 4 cycles.
- Overflow (ACC_W=8 instance):
  - Stimulus: beats 0xFF, then 0x02 with in_last.
  - Response: nibbles 1,0; overflow=1 during the drain; overflow=0 after returning to ACCUM. The next vector, 0x05 with in_last, gives nibbles 5,0 with overflow=0.
- Back-pressure:
  - Stimulus: sum 0x1234, with out_ready low for 3 cycles at each nibble.
  - Response: each nibble (4,3,2,1) held stable for 4 cycles. in_valid pulses during the drain are ignored, and the next vector's sum is unaffected.
- Reset mid-drain:
  - Stimulus: assert rst_n low asynchronously (between clock edges) after nibble 1 of sum 0xABCD.
  - Response: out_valid=0 immediately, in_ready=1 after release. A new vector 0x07 with in_last gives nibbles 7,0,0,0 with term_count=1.
- Counter saturation (CNT_W=4):
  - Stimulus: 20 beats of 0x01, the last with in_last.
  - Response: sum 0x0014 gives nibbles 4,1,0,0; term_count=15.
